// File: rtl/tube_pkg.sv
// Shared constants for the tube host register block: flag bit positions,
// host address map and clear-pulse timing.
package tube_pkg;

    localparam int FLAG_Q    = 0;
    localparam int FLAG_I    = 1;
    localparam int FLAG_J    = 2;
    localparam int FLAG_M    = 3;
    localparam int FLAG_V    = 4;
    localparam int FLAG_P    = 5;
    localparam int FLAG_T    = 6;
    localparam int NUM_FLAGS = 7;

    // Even addresses are status/control, odd addresses are FIFO data ports.
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam int         ADDR_DATA_BIT = 0;
    localparam logic [5:0] STATUS_PAD    = 6'h3F;

    localparam int                    CLR_CYCLES = 4;
    localparam int                    CLR_CNT_W  = 2;
    localparam logic [CLR_CNT_W-1:0]  CLR_LOAD   = CLR_CNT_W'(CLR_CYCLES - 1);

    typedef logic [NUM_FLAGS-2:0] stored_flags_t;

endpackage

// File: rtl/tube_clr_pulse.sv
// FIFO clear pulse generator: holds clr_b low for CLR_CYCLES clocks after
// start; a new start during a clear restarts the count.
//
//  state    | meaning
//  ST_IDLE  | clr_b high, waiting for start
//  ST_CLEAR | clr_b low, down-counter running to terminal count 0
module tube_clr_pulse
    import tube_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    output logic clr_b
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    logic                 state;
    logic [CLR_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (start) begin
            state <= ST_CLEAR;
            cnt   <= CLR_LOAD;
        end else if (state == ST_CLEAR) begin
            if (cnt == '0)
                state <= ST_IDLE;
            else
                cnt <= cnt - 1'b1;
        end
    end

    assign clr_b = (state == ST_IDLE);

endmodule

// File: rtl/tube_host_regs.sv
// Host-side register interface of the tube: access decode, FIFO strobes,
// control flags, status readback, FIFO clear and host interrupt.
module tube_host_regs
    import tube_pkg::*;
(
    input  logic       h_phi2,
    input  logic       h_rst_b,
    input  logic       h_cs_b,
    input  logic       h_rdnw,
    input  logic [2:0] h_addr,
    input  logic [7:0] h_din,
    output logic [7:0] h_dout,
    input  logic [7:0] ph_h_data,
    input  logic [3:0] ph_h_data_available,
    input  logic       ph_h_zero_bytes_available,
    input  logic [3:0] hp_h_not_full,
    output logic [3:0] h_selectData,
    output logic       h_rd,
    output logic       h_wr,
    output logic [6:0] flags,
    output logic       one_byte_mode,
    output logic       fifo_clr_b,
    output logic       p_rst_req,
    output logic       h_irq_b
);

    logic          access;
    logic          new_access;
    logic          data_port;
    logic [1:0]    sel_idx;
    logic          prev_access;
    logic [2:0]    prev_addr;
    logic          prev_rdnw;
    stored_flags_t flag_q;
    stored_flags_t flag_next;
    logic          flag_wr;
    logic          clr_start;
    logic [7:0]    status_byte;
    logic          unused_debug;

    assign unused_debug = ph_h_zero_bytes_available;

    assign access     = ~h_cs_b;
    assign new_access = access & ~(prev_access & (prev_addr == h_addr) & (prev_rdnw == h_rdnw));
    assign data_port  = h_addr[ADDR_DATA_BIT];
    assign sel_idx    = h_addr[2:1];

    assign h_rd = new_access &  h_rdnw & data_port & fifo_clr_b;
    assign h_wr = new_access & ~h_rdnw & data_port & fifo_clr_b;

    always_comb begin
        h_selectData = '0;
        if (access && data_port)
            h_selectData[sel_idx] = 1'b1;
    end

    assign status_byte = {ph_h_data_available[sel_idx], hp_h_not_full[sel_idx],
                          (h_addr == ADDR_CTRL) ? flag_q : STATUS_PAD};

    always_comb begin
        h_dout = 8'hFF;
        if (access && h_rdnw)
            h_dout = data_port ? ph_h_data : status_byte;
    end

    assign flag_wr = access & ~h_rdnw & (h_addr == ADDR_CTRL);

    always_comb begin
        flag_next = flag_q;
        if (flag_wr) begin
            if (h_din[7])
                flag_next = flag_q | h_din[FLAG_P:FLAG_Q];
            else
                flag_next = flag_q & ~h_din[FLAG_P:FLAG_Q];
        end
    end

    // T is never stored: setting it launches the clear pulse on the same edge.
    assign clr_start = flag_wr & h_din[7] & h_din[FLAG_T];

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            prev_access <= 1'b0;
            prev_addr   <= '0;
            prev_rdnw   <= 1'b0;
            flag_q      <= '0;
            h_irq_b     <= 1'b1;
        end else begin
            prev_access <= access;
            prev_addr   <= h_addr;
            prev_rdnw   <= h_rdnw;
            flag_q      <= flag_next;
            // Uses the post-write Q so a same-cycle clear suppresses the IRQ.
            h_irq_b     <= ~(flag_next[FLAG_Q] & ph_h_data_available[3]);
        end
    end

    tube_clr_pulse u_clr_pulse (
        .clk   (h_phi2),
        .rst_b (h_rst_b),
        .start (clr_start),
        .clr_b (fifo_clr_b)
    );

    assign flags         = {1'b0, flag_q};
    assign one_byte_mode = flag_q[FLAG_V];
    assign p_rst_req     = ~h_rst_b | flag_q[FLAG_P] | ~fifo_clr_b;

endmodule

// File: tb/tb_tube_host_regs.sv
// Scoreboard bench for tube_host_regs: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_tube_host_regs;

    logic       h_phi2 = 1'b0;
    logic       h_rst_b = 1'b0;
    logic       h_cs_b = 1'b1;
    logic       h_rdnw = 1'b1;
    logic [2:0] h_addr = '0;
    logic [7:0] h_din = '0;
    logic [7:0] h_dout;
    logic [7:0] ph_h_data = '0;
    logic [3:0] ph_h_data_available = '0;
    logic       ph_h_zero_bytes_available = 1'b0;
    logic [3:0] hp_h_not_full = '0;
    logic [3:0] h_selectData;
    logic       h_rd;
    logic       h_wr;
    logic [6:0] flags;
    logic       one_byte_mode;
    logic       fifo_clr_b;
    logic       p_rst_req;
    logic       h_irq_b;

    tube_host_regs dut (
        .h_phi2                    (h_phi2),
        .h_rst_b                   (h_rst_b),
        .h_cs_b                    (h_cs_b),
        .h_rdnw                    (h_rdnw),
        .h_addr                    (h_addr),
        .h_din                     (h_din),
        .h_dout                    (h_dout),
        .ph_h_data                 (ph_h_data),
        .ph_h_data_available       (ph_h_data_available),
        .ph_h_zero_bytes_available (ph_h_zero_bytes_available),
        .hp_h_not_full             (hp_h_not_full),
        .h_selectData              (h_selectData),
        .h_rd                      (h_rd),
        .h_wr                      (h_wr),
        .flags                     (flags),
        .one_byte_mode             (one_byte_mode),
        .fifo_clr_b                (fifo_clr_b),
        .p_rst_req                 (p_rst_req),
        .h_irq_b                   (h_irq_b)
    );

    always #5 h_phi2 = ~h_phi2;

    typedef struct {
        string      tag;
        logic [7:0] dout;
        logic [3:0] sel;
        logic       rd;
        logic       wr;
        logic [6:0] flags;
        logic       obm;
        logic       clr_b;
        logic       prst;
        logic       irq_b;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: stored flags {P,V,M,J,I,Q}, clear cycles still
    // owed, last sampled bus cycle, and the registered IRQ line.
    logic [5:0] m_flags = '0;
    int         m_clr_left = 0;
    bit         m_prev_acc = 0;
    logic [2:0] m_prev_addr = '0;
    logic       m_prev_rdnw = 1'b0;
    logic       m_irq_b = 1'b1;

    task automatic chk(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
        end
    endtask

    always @(negedge h_phi2) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, "h_dout", h_dout, e.dout);
            chk(e.tag, "h_selectData", 8'(h_selectData), 8'(e.sel));
            chk(e.tag, "h_rd", 8'(h_rd), 8'(e.rd));
            chk(e.tag, "h_wr", 8'(h_wr), 8'(e.wr));
            chk(e.tag, "flags", 8'(flags), 8'(e.flags));
            chk(e.tag, "one_byte_mode", 8'(one_byte_mode), 8'(e.obm));
            chk(e.tag, "fifo_clr_b", 8'(fifo_clr_b), 8'(e.clr_b));
            chk(e.tag, "p_rst_req", 8'(p_rst_req), 8'(e.prst));
            chk(e.tag, "h_irq_b", 8'(h_irq_b), 8'(e.irq_b));
        end
    end

    task automatic drive(input logic cs_b, input logic rdnw, input logic [2:0] addr,
                         input logic [7:0] din, input logic [3:0] av, input logic [3:0] nf,
                         input logic [7:0] data, input string tag);
        exp_t e;
        bit   acc, is_new, clr_low, start;
        int   idx;
        @(posedge h_phi2);
        #1;
        h_cs_b = cs_b; h_rdnw = rdnw; h_addr = addr; h_din = din;
        ph_h_data_available = av; hp_h_not_full = nf; ph_h_data = data;
        ph_h_zero_bytes_available = 1'($urandom_range(0, 1));

        acc     = (cs_b == 1'b0);
        is_new  = acc && !(m_prev_acc && m_prev_addr == addr && m_prev_rdnw == rdnw);
        clr_low = (m_clr_left > 0);
        idx     = int'(addr) / 2;

        e.tag   = tag;
        e.rd    = is_new && rdnw && (addr % 2 == 1) && !clr_low;
        e.wr    = is_new && !rdnw && (addr % 2 == 1) && !clr_low;
        e.sel   = (acc && addr % 2 == 1) ? 4'(1 << idx) : 4'b0000;
        if (acc && rdnw)
            e.dout = (addr % 2 == 1) ? data : {av[idx], nf[idx], (addr == 0) ? m_flags : 6'h3F};
        else
            e.dout = 8'hFF;
        e.flags = {1'b0, m_flags};
        e.obm   = m_flags[4];
        e.clr_b = !clr_low;
        e.prst  = m_flags[5] || clr_low;
        e.irq_b = m_irq_b;
        sb.push_back(e);

        start = 0;
        if (acc && !rdnw && addr == 0) begin
            if (din[7]) begin
                m_flags = m_flags | din[5:0];
                start   = din[6];
            end else begin
                m_flags = m_flags & ~din[5:0];
            end
        end
        if (start) m_clr_left = 4;
        else if (m_clr_left > 0) m_clr_left--;
        m_irq_b     = !(m_flags[0] && av[3]);
        m_prev_acc  = acc;
        m_prev_addr = addr;
        m_prev_rdnw = rdnw;
    endtask

    task automatic idle(input int n, input logic [3:0] av, input string tag);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b1, 3'd0, 8'h00, av, 4'h0, 8'h00, tag);
    endtask

    task automatic reset_cycle(input string tag);
        exp_t e;
        @(posedge h_phi2);
        #1;
        h_rst_b = 1'b0;
        h_cs_b  = 1'b1;
        #1;
        chk(tag, "fifo_clr_b_now", 8'(fifo_clr_b), 8'h01);
        chk(tag, "p_rst_req_now", 8'(p_rst_req), 8'h01);
        e.tag = tag; e.dout = 8'hFF; e.sel = 4'h0; e.rd = 1'b0; e.wr = 1'b0;
        e.flags = 7'h00; e.obm = 1'b0; e.clr_b = 1'b1; e.prst = 1'b1; e.irq_b = 1'b1;
        sb.push_back(e);
        m_flags = '0; m_clr_left = 0; m_prev_acc = 0; m_irq_b = 1'b1;
        @(posedge h_phi2);
        #1;
        h_rst_b = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic       cs_b, rdnw;
        logic [2:0] addr;
        reset_cycle("reset");

        drive(1'b0, 1'b0, 3'd0, 8'hFF, 4'h0, 4'h0, 8'h00, "wr_ff");
        idle(5, 4'h0, "clr_run");
        drive(1'b0, 1'b1, 3'd0, 8'h00, 4'h1, 4'h0, 8'h00, "rd_ctrl_after_clr");

        drive(1'b0, 1'b0, 3'd0, 8'h3F, 4'h8, 4'h0, 8'h00, "clr_all");
        drive(1'b0, 1'b0, 3'd0, 8'h01, 4'h8, 4'h0, 8'h00, "wr_q_clr");
        drive(1'b0, 1'b0, 3'd0, 8'h81, 4'h8, 4'h0, 8'h00, "wr_q_set");
        idle(2, 4'h8, "irq_low");
        idle(2, 4'h0, "irq_src_gone");

        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 3'd1, 8'h00, 4'h1, 4'h0, 8'hA5, "held_rd1");
        idle(1, 4'h0, "gap");

        drive(1'b0, 1'b1, 3'd4, 8'h00, 4'b0100, 4'b0100, 8'h00, "rd4_ones");
        drive(1'b0, 1'b1, 3'd4, 8'h00, 4'b0000, 4'b0000, 8'h00, "rd4_zeros");

        drive(1'b0, 1'b0, 3'd2, 8'hFF, 4'h0, 4'h0, 8'h00, "wr2_ignored");
        drive(1'b0, 1'b0, 3'd0, 8'hC0, 4'h0, 4'h0, 8'h00, "start_clr");
        drive(1'b0, 1'b0, 3'd7, 8'h5A, 4'h0, 4'h0, 8'h00, "wr7_in_clr");
        drive(1'b1, 1'b1, 3'd0, 8'h00, 4'h0, 4'h0, 8'h00, "mid_clr");
        drive(1'b0, 1'b0, 3'd0, 8'hC0, 4'h0, 4'h0, 8'h00, "restart_clr");
        idle(1, 4'h0, "restart_run");
        reset_cycle("reset_mid_clr");
        drive(1'b0, 1'b1, 3'd5, 8'h00, 4'h0, 4'h0, 8'h3C, "first_after_rst");

        cs_b = 1'b1; rdnw = 1'b1; addr = 3'd0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_cycle("reset_rand");
            if ($urandom_range(0, 3) != 0) begin
                cs_b = 1'($urandom_range(0, 4) == 0);
                rdnw = 1'($urandom_range(0, 1));
                addr = 3'($urandom_range(0, 7));
            end
            drive(cs_b, rdnw, addr, 8'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), "rand");
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge h_phi2);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
